// File: rtl/registro_id_ex.sv
`default_nettype none
// ============================================================================
//  Module      : registro_id_ex
//  Description : ID/EX pipeline register with load-use hazard detection.
//                A load in EX whose destination (rt) is read by the ID
//                instruction raises 'stall' for one cycle. During that cycle
//                a bubble enters EX. 'flush' squashes the ID instruction and
//                takes priority over a stall.
//  Ports       : clk, reset (sync, active-low)
//                id_* : decoded ID-stage instruction fields (inputs)
//                flush: squash ID instruction (input)
//                stall: hold PC and IF/ID this cycle (output, combinational)
//                ex_* : registered EX-stage fields (outputs)
//                stall_count : saturating stall counter (output, optional)
//  Options     : REGISTRO_ID_EX_STALL_CNT_EN adds the 16-bit stall_count port.
//  Revision    : 1.0 - initial release
// ============================================================================
module registro_id_ex (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic [4:0]  id_rd,
    input  logic        id_uses_rt,
    input  logic [31:0] id_rd1,
    input  logic [31:0] id_rd2,
    input  logic [31:0] id_imm,
    input  logic [9:0]  id_ctrl,
    input  logic        flush,
    output logic        stall,
    output logic        ex_valid,
    output logic [4:0]  ex_rs,
    output logic [4:0]  ex_rt,
    output logic [4:0]  ex_wreg,
    output logic [31:0] ex_rd1,
    output logic [31:0] ex_rd2,
    output logic [31:0] ex_imm,
    output logic [9:0]  ex_ctrl
`ifdef REGISTRO_ID_EX_STALL_CNT_EN
    ,
    output logic [15:0] stall_count
`endif
);

    localparam logic [0:0] c_RUN    = 1'b0;
    localparam logic [0:0] c_BUBBLE = 1'b1;

    logic [0:0]  r_state;
    logic        r_ex_valid;
    logic [4:0]  r_ex_rs;
    logic [4:0]  r_ex_rt;
    logic [4:0]  r_ex_wreg;
    logic [31:0] r_ex_rd1;
    logic [31:0] r_ex_rd2;
    logic [31:0] r_ex_imm;
    logic [9:0]  r_ex_ctrl;

    logic        w_hazard;
    logic        w_stall;
    logic [4:0]  w_wreg;
    logic [9:0]  w_ctrl_cap;

    // A load targeting r0 never produces a value worth waiting for, so the
    // non-zero test on ex_rt also makes rs/rt == 0 hazard-free.
    assign w_hazard = r_ex_valid & r_ex_ctrl[1] & (r_ex_rt != 5'd0) & id_valid &
                      ((r_ex_rt == id_rs) | (id_uses_rt & (r_ex_rt == id_rt)));

    // Stall is suppressed during reset, while the bubble is in flight
    // (at most one stall cycle per load) and when the ID slot is flushed.
    assign w_stall = reset & (r_state == c_RUN) & w_hazard & ~flush;

    assign w_wreg = id_ctrl[5] ? id_rd : id_rt;

    // Writes to r0 are dropped here so later stages need not check.
    assign w_ctrl_cap = id_valid ? {id_ctrl[9:1], id_ctrl[0] & (w_wreg != 5'd0)}
                                 : 10'd0;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= c_RUN;
            r_ex_valid <= 1'b0;
            r_ex_ctrl  <= 10'd0;
            r_ex_rs    <= 5'd0;
            r_ex_rt    <= 5'd0;
            r_ex_wreg  <= 5'd0;
            r_ex_rd1   <= 32'd0;
            r_ex_rd2   <= 32'd0;
            r_ex_imm   <= 32'd0;
        end else begin
            // Data fields follow ID every cycle; a bubble is defined solely
            // by ex_valid/ex_ctrl being cleared.
            r_ex_rs   <= id_rs;
            r_ex_rt   <= id_rt;
            r_ex_wreg <= w_wreg;
            r_ex_rd1  <= id_rd1;
            r_ex_rd2  <= id_rd2;
            r_ex_imm  <= id_imm;
            if (flush) begin
                r_ex_valid <= 1'b0;
                r_ex_ctrl  <= 10'd0;
                r_state    <= c_RUN;
            end else if (w_stall) begin
                r_ex_valid <= 1'b0;
                r_ex_ctrl  <= 10'd0;
                r_state    <= c_BUBBLE;
            end else begin
                r_ex_valid <= id_valid;
                r_ex_ctrl  <= w_ctrl_cap;
                r_state    <= c_RUN;
            end
        end
    end

`ifdef REGISTRO_ID_EX_STALL_CNT_EN
    logic [15:0] r_stall_count;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stall_count <= 16'd0;
        end else if (w_stall && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign stall_count = r_stall_count;
`endif

    assign stall    = w_stall;
    assign ex_valid = r_ex_valid;
    assign ex_rs    = r_ex_rs;
    assign ex_rt    = r_ex_rt;
    assign ex_wreg  = r_ex_wreg;
    assign ex_rd1   = r_ex_rd1;
    assign ex_rd2   = r_ex_rd2;
    assign ex_imm   = r_ex_imm;
    assign ex_ctrl  = r_ex_ctrl;

endmodule
`default_nettype wire

// File: tb/tb_registro_id_ex.sv
`default_nettype none
// ============================================================================
//  Module      : tb_registro_id_ex
//  Description : Self-checking bench for registro_id_ex. Expected EX contents
//                are queued when each ID instruction is driven and compared
//                after the following clock edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_registro_id_ex;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rs = 5'd0;
    logic [4:0]  id_rt = 5'd0;
    logic [4:0]  id_rd = 5'd0;
    logic        id_uses_rt = 1'b0;
    logic [31:0] id_rd1 = 32'd0;
    logic [31:0] id_rd2 = 32'd0;
    logic [31:0] id_imm = 32'd0;
    logic [9:0]  id_ctrl = 10'd0;
    logic        flush = 1'b0;
    logic        stall;
    logic        ex_valid;
    logic [4:0]  ex_rs;
    logic [4:0]  ex_rt;
    logic [4:0]  ex_wreg;
    logic [31:0] ex_rd1;
    logic [31:0] ex_rd2;
    logic [31:0] ex_imm;
    logic [9:0]  ex_ctrl;
`ifdef REGISTRO_ID_EX_STALL_CNT_EN
    logic [15:0] stall_count;
    int          exp_cnt = 0;
`endif

    registro_id_ex dut (
        .clk        (clk),
        .reset      (reset),
        .id_valid   (id_valid),
        .id_rs      (id_rs),
        .id_rt      (id_rt),
        .id_rd      (id_rd),
        .id_uses_rt (id_uses_rt),
        .id_rd1     (id_rd1),
        .id_rd2     (id_rd2),
        .id_imm     (id_imm),
        .id_ctrl    (id_ctrl),
        .flush      (flush),
        .stall      (stall),
        .ex_valid   (ex_valid),
        .ex_rs      (ex_rs),
        .ex_rt      (ex_rt),
        .ex_wreg    (ex_wreg),
        .ex_rd1     (ex_rd1),
        .ex_rd2     (ex_rd2),
        .ex_imm     (ex_imm),
        .ex_ctrl    (ex_ctrl)
`ifdef REGISTRO_ID_EX_STALL_CNT_EN
        ,
        .stall_count(stall_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [9:0]  c;
        logic        chk;
        logic [4:0]  w;
        logic [31:0] d1;
        logic [31:0] im;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    logic es;
    int   n_assert = 0;
    int   n_fail   = 0;

    function automatic exp_t mk(input logic v, input logic [9:0] c, input logic chk,
                                input logic [4:0] w, input logic [31:0] d1,
                                input logic [31:0] im);
        exp_t r;
        r.v = v; r.c = c; r.chk = chk; r.w = w; r.d1 = d1; r.im = im;
        return r;
    endfunction

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic urt, input logic [31:0] d1,
                         input logic [31:0] im, input logic [9:0] c, input logic fl);
        id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_uses_rt = urt;
        id_rd1 = d1; id_rd2 = ~d1; id_imm = im; id_ctrl = c; flush = fl;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        for (int s = 0; s < 2; s++) begin
            drive(1'b1, 5'd8, 5'd8, 5'd3, 1'b1, 32'hDEAD, 32'hBEEF, 10'h3FF, 1'b1);
            sb.push_back(mk(1'b0, 10'h000, 1'b1, 5'd0, 32'd0, 32'd0));
            es = 1'b0;
            #1;
            n_assert++;
            if (stall !== es) begin
                n_fail++;
                $display("FAIL reset step %0d stall: got %b want %b", s, stall, es);
            end
            tick();
            e = sb.pop_front();
            n_assert++;
            if (ex_valid !== e.v || ex_ctrl !== e.c ||
                (e.chk && (ex_wreg !== e.w || ex_rd1 !== e.d1 || ex_imm !== e.im))) begin
                n_fail++;
                $display("FAIL reset step %0d ex: got v=%b ctrl=%h wreg=%0d rd1=%h imm=%h want v=%b ctrl=%h wreg=%0d rd1=%h imm=%h",
                         s, ex_valid, ex_ctrl, ex_wreg, ex_rd1, ex_imm, e.v, e.c, e.w, e.d1, e.im);
            end
        end
        n_assert++;
        if (ex_rs !== 5'd0 || ex_rt !== 5'd0 || ex_rd2 !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_fields: got rs=%0d rt=%0d rd2=%h want 0 0 0", ex_rs, ex_rt, ex_rd2);
        end
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 32'd0, 10'd0, 1'b0);
        reset = 1'b1;
`ifdef REGISTRO_ID_EX_STALL_CNT_EN
        n_assert++;
        if (stall_count !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_count: got %0d want 0", stall_count);
        end
`endif
    endtask

    task automatic test_capture();
        for (int s = 0; s < 3; s++) begin
            case (s)
                0: begin
                    drive(1'b1, 5'd2, 5'd3, 5'd7, 1'b1, 32'h1234, 32'hFFFF_FFFC, 10'h021, 1'b0);
                    sb.push_back(mk(1'b1, 10'h021, 1'b1, 5'd7, 32'h1234, 32'hFFFF_FFFC));
                end
                1: begin
                    drive(1'b0, 5'd1, 5'd2, 5'd3, 1'b0, 32'h77, 32'h5, 10'h3FF, 1'b0);
                    sb.push_back(mk(1'b0, 10'h000, 1'b1, 5'd3, 32'h77, 32'h5));
                end
                default: begin
                    drive(1'b1, 5'd4, 5'd5, 5'd6, 1'b1, 32'hCAFE, 32'h10, 10'h3C1, 1'b0);
                    sb.push_back(mk(1'b1, 10'h3C1, 1'b1, 5'd5, 32'hCAFE, 32'h10));
                end
            endcase
            es = 1'b0;
            #1;
            n_assert++;
            if (stall !== es) begin
                n_fail++;
                $display("FAIL capture step %0d stall: got %b want %b", s, stall, es);
            end
            tick();
            e = sb.pop_front();
            n_assert++;
            if (ex_valid !== e.v || ex_ctrl !== e.c ||
                (e.chk && (ex_wreg !== e.w || ex_rd1 !== e.d1 || ex_imm !== e.im))) begin
                n_fail++;
                $display("FAIL capture step %0d ex: got v=%b ctrl=%h wreg=%0d rd1=%h imm=%h want v=%b ctrl=%h wreg=%0d rd1=%h imm=%h",
                         s, ex_valid, ex_ctrl, ex_wreg, ex_rd1, ex_imm, e.v, e.c, e.w, e.d1, e.im);
            end
        end
    endtask

    // Load in EX feeding rs, then a dependency through rt gated by id_uses_rt.
    task automatic test_load_use();
        for (int s = 0; s < 7; s++) begin
            es = 1'b0;
            case (s)
                0: begin
                    drive(1'b1, 5'd1, 5'd8, 5'd0, 1'b0, 32'h11, 32'h4, 10'h01B, 1'b0);
                    sb.push_back(mk(1'b1, 10'h01B, 1'b1, 5'd8, 32'h11, 32'h4));
                end
                1: begin
                    drive(1'b1, 5'd8, 5'd9, 5'd10, 1'b0, 32'hAAAA, 32'h20, 10'h021, 1'b0);
                    sb.push_back(mk(1'b0, 10'h000, 1'b0, 5'd0, 32'd0, 32'd0));
                    es = 1'b1;
                end
                2: begin
                    sb.push_back(mk(1'b1, 10'h021, 1'b1, 5'd10, 32'hAAAA, 32'h20));
                end
                3: begin
                    drive(1'b1, 5'd2, 5'd5, 5'd0, 1'b0, 32'h1, 32'h0, 10'h01B, 1'b0);
                    sb.push_back(mk(1'b1, 10'h01B, 1'b1, 5'd5, 32'h1, 32'h0));
                end
                4: begin
                    // rt matches but is not a source: no stall, next load captured
                    drive(1'b1, 5'd3, 5'd5, 5'd6, 1'b0, 32'h2, 32'h1, 10'h01B, 1'b0);
                    sb.push_back(mk(1'b1, 10'h01B, 1'b1, 5'd5, 32'h2, 32'h1));
                end
                5: begin
                    drive(1'b1, 5'd3, 5'd5, 5'd6, 1'b1, 32'h3, 32'h2, 10'h021, 1'b0);
                    sb.push_back(mk(1'b0, 10'h000, 1'b0, 5'd0, 32'd0, 32'd0));
                    es = 1'b1;
                end
                default: begin
                    sb.push_back(mk(1'b1, 10'h021, 1'b1, 5'd6, 32'h3, 32'h2));
                end
            endcase
            #1;
            n_assert++;
            if (stall !== es) begin
                n_fail++;
                $display("FAIL load_use step %0d stall: got %b want %b", s, stall, es);
            end
`ifdef REGISTRO_ID_EX_STALL_CNT_EN
            if (es) exp_cnt++;
`endif
            tick();
            e = sb.pop_front();
            n_assert++;
            if (ex_valid !== e.v || ex_ctrl !== e.c ||
                (e.chk && (ex_wreg !== e.w || ex_rd1 !== e.d1 || ex_imm !== e.im))) begin
                n_fail++;
                $display("FAIL load_use step %0d ex: got v=%b ctrl=%h wreg=%0d rd1=%h imm=%h want v=%b ctrl=%h wreg=%0d rd1=%h imm=%h",
                         s, ex_valid, ex_ctrl, ex_wreg, ex_rd1, ex_imm, e.v, e.c, e.w, e.d1, e.im);
            end
        end
    endtask

    // Flush during a hazard, then flush arriving in the bubble cycle.
    task automatic test_flush();
        for (int s = 0; s < 6; s++) begin
            es = 1'b0;
            case (s)
                0, 2: begin
                    drive(1'b1, 5'd1, 5'd8, 5'd0, 1'b0, 32'h5, 32'h0, 10'h01B, 1'b0);
                    sb.push_back(mk(1'b1, 10'h01B, 1'b1, 5'd8, 32'h5, 32'h0));
                end
                1: begin
                    drive(1'b1, 5'd8, 5'd9, 5'd10, 1'b0, 32'h4, 32'h0, 10'h021, 1'b1);
                    sb.push_back(mk(1'b0, 10'h000, 1'b0, 5'd0, 32'd0, 32'd0));
                end
                3: begin
                    drive(1'b1, 5'd8, 5'd9, 5'd10, 1'b0, 32'h6, 32'h0, 10'h021, 1'b0);
                    sb.push_back(mk(1'b0, 10'h000, 1'b0, 5'd0, 32'd0, 32'd0));
                    es = 1'b1;
                end
                4: begin
                    flush = 1'b1;
                    sb.push_back(mk(1'b0, 10'h000, 1'b0, 5'd0, 32'd0, 32'd0));
                end
                default: begin
                    drive(1'b1, 5'd8, 5'd9, 5'd10, 1'b0, 32'h7, 32'h0, 10'h021, 1'b0);
                    sb.push_back(mk(1'b1, 10'h021, 1'b1, 5'd10, 32'h7, 32'h0));
                end
            endcase
            #1;
            n_assert++;
            if (stall !== es) begin
                n_fail++;
                $display("FAIL flush step %0d stall: got %b want %b", s, stall, es);
            end
`ifdef REGISTRO_ID_EX_STALL_CNT_EN
            if (es) exp_cnt++;
`endif
            tick();
            e = sb.pop_front();
            n_assert++;
            if (ex_valid !== e.v || ex_ctrl !== e.c ||
                (e.chk && (ex_wreg !== e.w || ex_rd1 !== e.d1 || ex_imm !== e.im))) begin
                n_fail++;
                $display("FAIL flush step %0d ex: got v=%b ctrl=%h wreg=%0d rd1=%h imm=%h want v=%b ctrl=%h wreg=%0d rd1=%h imm=%h",
                         s, ex_valid, ex_ctrl, ex_wreg, ex_rd1, ex_imm, e.v, e.c, e.w, e.d1, e.im);
            end
        end
    endtask

    // r0 as load target / source never stalls; writes to r0 lose RegWrite.
    task automatic test_zero_reg();
        for (int s = 0; s < 3; s++) begin
            case (s)
                0: begin
                    drive(1'b1, 5'd1, 5'd0, 5'd0, 1'b0, 32'h8, 32'h0, 10'h01B, 1'b0);
                    sb.push_back(mk(1'b1, 10'h01A, 1'b1, 5'd0, 32'h8, 32'h0));
                end
                1: begin
                    drive(1'b1, 5'd0, 5'd0, 5'd3, 1'b1, 32'h9, 32'h0, 10'h001, 1'b0);
                    sb.push_back(mk(1'b1, 10'h000, 1'b1, 5'd0, 32'h9, 32'h0));
                end
                default: begin
                    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 32'hA, 32'h3, 10'h021, 1'b0);
                    sb.push_back(mk(1'b1, 10'h020, 1'b1, 5'd0, 32'hA, 32'h3));
                end
            endcase
            es = 1'b0;
            #1;
            n_assert++;
            if (stall !== es) begin
                n_fail++;
                $display("FAIL zero_reg step %0d stall: got %b want %b", s, stall, es);
            end
            tick();
            e = sb.pop_front();
            n_assert++;
            if (ex_valid !== e.v || ex_ctrl !== e.c ||
                (e.chk && (ex_wreg !== e.w || ex_rd1 !== e.d1 || ex_imm !== e.im))) begin
                n_fail++;
                $display("FAIL zero_reg step %0d ex: got v=%b ctrl=%h wreg=%0d rd1=%h imm=%h want v=%b ctrl=%h wreg=%0d rd1=%h imm=%h",
                         s, ex_valid, ex_ctrl, ex_wreg, ex_rd1, ex_imm, e.v, e.c, e.w, e.d1, e.im);
            end
        end
    endtask

    task automatic test_reset_mid_stall();
`ifdef REGISTRO_ID_EX_STALL_CNT_EN
        n_assert++;
        if (stall_count !== 16'(exp_cnt)) begin
            n_fail++;
            $display("FAIL stall_count: got %0d want %0d", stall_count, exp_cnt);
        end
`endif
        for (int s = 0; s < 3; s++) begin
            case (s)
                0: begin
                    drive(1'b1, 5'd1, 5'd8, 5'd0, 1'b0, 32'hB, 32'h0, 10'h01B, 1'b0);
                    sb.push_back(mk(1'b1, 10'h01B, 1'b1, 5'd8, 32'hB, 32'h0));
                end
                1: begin
                    drive(1'b1, 5'd8, 5'd9, 5'd10, 1'b0, 32'hC, 32'h1, 10'h021, 1'b0);
                    #1;
                    n_assert++;
                    if (stall !== 1'b1) begin
                        n_fail++;
                        $display("FAIL mid_stall pre-reset stall: got %b want 1", stall);
                    end
                    reset = 1'b0;
                    sb.push_back(mk(1'b0, 10'h000, 1'b1, 5'd0, 32'd0, 32'd0));
                end
                default: begin
                    reset = 1'b1;
                    sb.push_back(mk(1'b1, 10'h021, 1'b1, 5'd10, 32'hC, 32'h1));
                end
            endcase
            es = 1'b0;
            #1;
            n_assert++;
            if (stall !== es) begin
                n_fail++;
                $display("FAIL mid_stall step %0d stall: got %b want %b", s, stall, es);
            end
            tick();
            e = sb.pop_front();
            n_assert++;
            if (ex_valid !== e.v || ex_ctrl !== e.c ||
                (e.chk && (ex_wreg !== e.w || ex_rd1 !== e.d1 || ex_imm !== e.im))) begin
                n_fail++;
                $display("FAIL mid_stall step %0d ex: got v=%b ctrl=%h wreg=%0d rd1=%h imm=%h want v=%b ctrl=%h wreg=%0d rd1=%h imm=%h",
                         s, ex_valid, ex_ctrl, ex_wreg, ex_rd1, ex_imm, e.v, e.c, e.w, e.d1, e.im);
            end
`ifdef REGISTRO_ID_EX_STALL_CNT_EN
            if (s == 1) begin
                n_assert++;
                if (stall_count !== 16'd0) begin
                    n_fail++;
                    $display("FAIL mid_stall count: got %0d want 0", stall_count);
                end
            end
`endif
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_capture();
        test_load_use();
        test_flush();
        test_zero_reg();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/registro_id_ex.md
REGISTRO_ID_EX -- requirements
Module: registro_id_ex

Interface
REQ-001 SHALL: clk  in  1  single system clock; all state updates on posedge clk.
REQ-002 SHALL: reset  in  1  synchronous, active-low reset, sampled on posedge clk.
REQ-003 SHALL: id_valid  in  1  ID stage holds a real instruction.
REQ-004 SHALL: id_rs, id_rt, id_rd  in  5 each  register specifiers of the ID instruction.
REQ-005 SHALL: id_uses_rt  in  1  ID instruction reads rt as a source.
REQ-006 SHALL: id_rd1, id_rd2  in  32 each  register-file read data for rs and rt.
REQ-007 SHALL: id_imm  in  32  sign-extended immediate.
REQ-008 SHALL: id_ctrl  in  10  control bits: [0]RegWrite [1]MemRead [2]MemWrite [3]MemtoReg [4]ALUSrc [5]RegDst [9:6]ALUOp.
REQ-009 SHALL: flush  in  1  squash the ID instruction (taken branch/jump).
REQ-010 SHALL: stall  out  1  hold PC and IF/ID this cycle (load-use hazard).
REQ-011 SHALL: ex_valid  out  1; ex_rs, ex_rt  out  5; ex_wreg  out  5; ex_rd1, ex_rd2, ex_imm  out  32; ex_ctrl  out  10  registered EX-stage fields.

Function
REQ-012 SHALL: hazard = ex_valid & ex_ctrl[1] & (ex_rt!=0) & id_valid & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)).
REQ-013 SHALL: stall equal hazard & ~flush, combinational, in the same cycle.
REQ-014 SHALL: on posedge with flush=1, load a bubble: ex_valid=0, ex_ctrl=0; flush overrides stall.
REQ-015 SHALL: on posedge with stall=1, load a bubble; ex_* data fields may hold any value but ex_ctrl SHALL be 0.
REQ-016 SHALL: otherwise capture all id_* fields into ex_* with one-cycle latency; ex_valid=id_valid; ex_ctrl=id_valid?id_ctrl:0.
REQ-017 SHALL: ex_wreg=id_ctrl[5]?id_rd:id_rt when captured; a captured ex_wreg of 0 forces ex_ctrl[0]=0.
REQ-018 SHALL: FSM states RUN and BUBBLE; RUN->BUBBLE on posedge with stall=1; BUBBLE->RUN unconditionally on the next posedge.
REQ-019 SHALL: in BUBBLE, stall is forced to 0 (at most one consecutive stall cycle per load).
REQ-020 SHALL: flush in BUBBLE still loads a bubble; flush in RUN forces next state RUN.
REQ-021 SHALL: id_rs=0 or id_rt=0 never cause a hazard, regardless of ex_rt.

Reset
REQ-022 SHALL: reset=0 at a posedge drive ex_valid=0, ex_ctrl=0, ex_rs=ex_rt=ex_wreg=0, ex_rd1=ex_rd2=ex_imm=0, FSM=RUN.
REQ-023 SHALL: stall read 0 in every cycle reset=0; reset overrides flush and stall; reset mid-stall returns to RUN.

Configuration
REQ-024 SHALL: macro REGISTRO_ID_EX_STALL_CNT_EN, when defined, add output stall_count out 16: increments on each posedge with stall=1, saturates at 16'hFFFF, clears on reset.
REQ-025 SHALL: without REGISTRO_ID_EX_STALL_CNT_EN, stall_count port and logic do not exist; all other behaviour identical.

Verification
REQ-026 SHALL: reset low 2 cycles, release -> all ex_* 0, stall 0, FSM RUN.
REQ-027 SHALL: id_valid=1, id_rd1=32'h1234, id_imm=32'hFFFF_FFFC, id_ctrl=10'h021, id_rd=7 -> next cycle ex_rd1=32'h1234, ex_imm=32'hFFFF_FFFC, ex_wreg=7, ex_ctrl=10'h021.
REQ-028 SHALL: ex holds lw (ctrl[1]=1, ex_rt=8), ID has id_rs=8 -> stall=1 for exactly one cycle, then ex_ctrl=0 bubble, then the ID instruction captured with stall=0.
REQ-029 SHALL: same hazard with flush=1 -> stall=0, bubble loaded, FSM stays RUN.
REQ-030 SHALL: lw with ex_rt=0 and id_rs=0 -> stall=0; captured id_ctrl=10'h001 with id_rt=0, RegDst=0 -> ex_ctrl[0]=0.
REQ-031 SHALL: with REGISTRO_ID_EX_STALL_CNT_EN, 3 separate load-use hazards -> stall_count=3; reset mid-stall -> stall_count=0, stall=0.
